nios2_ocimem_ctrl: RTL and testbench

Debug-monitor memory controller for the Nios II JTAG debug path. It sits directly downstream of the system-clock half of the JTAG debug module. It consumes the `jdo` word and the single-cycle `take_action_ocimem_*` strobes, and performs reads and writes into a small on-chip debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the TCK-side scan logic. The same RAM is also exposed to the CPU as an Avalon-MM slave, with JTAG accesses taking priority.

---
 rtl/nios2_ocimem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_nios2_ocimem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_ctrl.sv
// Debug-monitor RAM controller: JTAG monitor commands and an Avalon-MM CPU slave share one
// single-port synchronous RAM, with JTAG accesses taking priority.
module nios2_ocimem_ctrl #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    localparam int unsigned Depth = 1 << AW;

    typedef enum logic [1:0] {StIdle, StJrdWait, StCpuRdWait} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] mon_a_q, mon_a_d;
    logic [31:0]   mon_d_q, mon_d_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          load_done_q, load_done_d;
    logic          jpend_q, jpend_d;
    logic          jpend_wr_q, jpend_wr_d;
    logic [31:0]   jpend_data_q, jpend_data_d;
    logic [31:0]   readdata_q, readdata_d;

    logic [31:0]   ram [Depth];
    logic [31:0]   ram_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic          cpu_wr_grant;

    logic          do_a, do_b, do_n, a_ok, a_bad, queue_new;
    logic [9:0]    field_ext;
    logic          unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign field_ext  = {1'b0, jdo[17:9]};

    // Strobe priority: b over a over no_action.
    assign do_b      = take_action_ocimem_b;
    assign do_a      = take_action_ocimem_a & ~do_b;
    assign do_n      = take_no_action_ocimem_a & ~do_b & ~take_action_ocimem_a;
    assign a_ok      = do_a & (field_ext < 10'(Depth));
    assign a_bad     = do_a & ~(field_ext < 10'(Depth));
    assign queue_new = do_b | (a_ok & jdo[34]) | do_n;

    always_comb begin
        state_d      = state_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        ready_d      = ready_q;
        error_d      = error_q;
        load_done_d  = 1'b0;
        jpend_d      = jpend_q;
        jpend_wr_d   = jpend_wr_q;
        jpend_data_d = jpend_data_q;
        readdata_d   = readdata_q;
        ram_we       = 1'b0;
        ram_addr     = mon_a_q;
        ram_wdata    = jpend_data_q;
        ram_be       = 4'hf;
        cpu_wr_grant = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A strobe arriving this cycle also blocks the CPU so JTAG goes first.
                if (jpend_q) begin
                    jpend_d = 1'b0;
                    if (jpend_wr_q) begin
                        ram_we  = 1'b1;
                        mon_a_d = mon_a_q + AW'(1);
                        ready_d = 1'b1;
                    end else begin
                        state_d = StJrdWait;
                    end
                end else if (!queue_new && avs_write) begin
                    ram_we       = 1'b1;
                    ram_addr     = avs_address;
                    ram_wdata    = avs_writedata;
                    ram_be       = avs_byteenable;
                    cpu_wr_grant = 1'b1;
                end else if (!queue_new && avs_read) begin
                    ram_addr = avs_address;
                    state_d  = StCpuRdWait;
                end
            end
            StJrdWait: begin
                mon_d_d = ram_rdata;
                mon_a_d = mon_a_q + AW'(1);
                ready_d = 1'b1;
                state_d = StIdle;
            end
            StCpuRdWait: begin
                readdata_d = ram_rdata;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load_done_q) ready_d = 1'b1;

        // New strobes override completions landing in the same cycle.
        if (a_bad) begin
            error_d = 1'b1;
            ready_d = 1'b1;
        end
        if (a_ok) begin
            mon_a_d     = jdo[9 +: AW];
            error_d     = 1'b0;
            ready_d     = 1'b0;
            load_done_d = ~jdo[34];
        end
        if (do_b) begin
            mon_d_d = jdo[34:3];
            ready_d = 1'b0;
        end
        if (do_n) ready_d = 1'b0;
        if (queue_new) begin
            jpend_d      = 1'b1;
            jpend_wr_d   = do_b;
            jpend_data_d = jdo[34:3];
        end

        if (reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            load_done_q  <= 1'b0;
            jpend_q      <= 1'b0;
            jpend_wr_q   <= 1'b0;
            jpend_data_q <= '0;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            load_done_q  <= load_done_d;
            jpend_q      <= jpend_d;
            jpend_wr_q   <= jpend_wr_d;
            jpend_data_q <= jpend_data_d;
            readdata_q   <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rdata <= ram[ram_addr];
    end

    // Read data is forwarded straight from the RAM in the completing cycle, then held.
    assign avs_readdata    = (state_q == StCpuRdWait) ? ram_rdata : readdata_q;
    assign avs_waitrequest = (avs_read | avs_write) &
                             ~(cpu_wr_grant | (state_q == StCpuRdWait));
    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// Randomised bench for nios2_ocimem_ctrl against a transaction-level memory model,
// plus directed scenarios with hand-computed expectations.
module tb_nios2_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    nios2_ocimem_ctrl #(.AW(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_byteenable         (avs_byteenable),
        .avs_readdata           (avs_readdata),
        .avs_waitrequest        (avs_waitrequest),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    bit          chk_on = 1'b0;
    logic [31:0] mdl_mem [256];
    int          mdl_a = 0;
    logic [31:0] exp_md = '0;
    logic        exp_err = 1'b0;

    localparam int KLoad = 0, KWrite = 1, KRead = 2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("mon_err", 32'(monitor_error), 32'(exp_err));
            if (!avs_read && !avs_write) check("wait_idle", 32'(avs_waitrequest), 32'd0);
            if (monitor_ready) check("mon_dreg", MonDReg, exp_md);
            if (avs_read && !avs_waitrequest)
                check("cpu_rdata", avs_readdata, mdl_mem[avs_address]);
        end
    end

    // Issues one JTAG command and applies its effect to the model at the capturing edge.
    task automatic jtag(input int kind, input logic [8:0] addr, input logic rd,
                        input logic [31:0] data);
        logic [63:0] fill;
        fill = {$urandom, $urandom};
        jdo  = fill[37:0];
        if (kind == KWrite) begin
            jdo[34:3]            = data;
            take_action_ocimem_b = 1'b1;
        end else if (kind == KLoad) begin
            jdo[17:9]            = addr;
            jdo[34]              = rd;
            take_action_ocimem_a = 1'b1;
        end else begin
            take_no_action_ocimem_a = 1'b1;
        end
        @(posedge clk);
        if (kind == KWrite) begin
            mdl_mem[mdl_a] = data;
            exp_md         = data;
            mdl_a          = (mdl_a + 1) % 256;
        end else if (kind == KLoad) begin
            if (int'(addr) >= 256) begin
                exp_err = 1'b1;
            end else begin
                mdl_a   = int'(addr);
                exp_err = 1'b0;
                if (rd) begin
                    exp_md = mdl_mem[mdl_a];
                    mdl_a  = (mdl_a + 1) % 256;
                end
            end
        end else begin
            exp_md = mdl_mem[mdl_a];
            mdl_a  = (mdl_a + 1) % 256;
        end
        #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Counts not-ready cycles seen after the command's capturing edge.
    task automatic wait_ready(input string nm, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (monitor_ready) break;
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL %s: no monitor_ready after %0d cycles, want completion", nm, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             output int w);
        w = 0;
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mdl_mem[a][8*i +: 8] = d[8*i +: 8];
                break;
            end
            w++;
            if (w > 40) begin
                total++; bad++;
                $display("FAIL cpu_wr_timeout: waited %0d cycles, want grant", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int w);
        w = 0;
        d = '0;
        avs_address = a; avs_read = 1'b1;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                d = avs_readdata;
                break;
            end
            w++;
            if (w > 40) begin
                total++; bad++;
                $display("FAIL cpu_rd_timeout: waited %0d cycles, want data", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        avs_read = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] rd;

        reset = 1'b1; jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_rdata", avs_readdata, 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'd0);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_wait", 32'(avs_waitrequest), 32'd0);
        @(posedge clk); #1;
        chk_on = 1'b1;

        for (int i = 0; i < 256; i++) begin
            cpu_write(8'(i), init_val(i), 4'hf, n);
            if (i == 0) check("lat_cpu_wr", 32'(n), 32'd0);
        end
        cpu_read(8'h07, rd, n);
        check("lat_cpu_rd", 32'(n), 32'd1);
        check("init_rd7", rd, 32'h1007_0015);

        // Write then read back through JTAG
        jtag(KLoad, 9'h010, 1'b0, '0);
        wait_ready("ld10", n);       check("lat_load", 32'(n), 32'd1);
        jtag(KWrite, '0, 1'b0, 32'hDEAD_BEEF);
        wait_ready("wr10", n);       check("lat_write", 32'(n), 32'd1);
        check("wr_mondreg", MonDReg, 32'hDEAD_BEEF);
        jtag(KLoad, 9'h010, 1'b1, '0);
        wait_ready("rd10", n);       check("lat_read", 32'(n), 32'd2);
        check("rd_mondreg", MonDReg, 32'hDEAD_BEEF);

        // Auto-increment wraps 0xFF -> 0x00
        jtag(KLoad, 9'h0FF, 1'b0, '0);          wait_ready("ldff", n);
        jtag(KWrite, '0, 1'b0, 32'hAAAA_0001);  wait_ready("wra", n);
        jtag(KWrite, '0, 1'b0, 32'hBBBB_0002);  wait_ready("wrb", n);
        cpu_read(8'hFF, rd, n);  check("wrap_ff", rd, 32'hAAAA_0001);
        cpu_read(8'h00, rd, n);  check("wrap_00", rd, 32'hBBBB_0002);

        // Out-of-range load keeps MonAReg (now 0x01) and writes nothing
        jtag(KLoad, 9'h100, 1'b0, '0);
        wait_ready("oor", n);    check("lat_oor", 32'(n), 32'd0);
        check("oor_err", 32'(monitor_error), 32'd1);
        jtag(KRead, '0, 1'b0, '0);
        wait_ready("oor_rd", n); check("oor_mona", MonDReg, 32'h1001_0003);
        cpu_read(8'h00, rd, n);  check("oor_nowr", rd, 32'hBBBB_0002);
        jtag(KLoad, 9'h005, 1'b1, '0);
        wait_ready("ld5", n);
        check("err_clr", 32'(monitor_error), 32'd0);
        check("ld5_data", MonDReg, 32'h1005_000F);

        // JTAG write and CPU read of the same word in the same cycle
        jtag(KLoad, 9'h020, 1'b0, '0);
        wait_ready("ld20", n);
        jdo = {3'b0, 32'hCAFE_F00D, 3'b0};
        take_action_ocimem_b = 1'b1;
        avs_address = 8'h20; avs_read = 1'b1;
        @(negedge clk);
        n = avs_waitrequest ? 1 : 0;
        @(posedge clk);
        mdl_mem[8'h20] = 32'hCAFE_F00D; exp_md = 32'hCAFE_F00D; mdl_a = 8'h21;
        #1 take_action_ocimem_b = 1'b0;
        rd = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                rd = avs_readdata;
                break;
            end
            n++;
        end
        @(posedge clk); #1 avs_read = 1'b0;
        check("cont_wait", 32'(n), 32'd3);
        check("cont_data", rd, 32'hCAFE_F00D);

        // Byte enables
        cpu_write(8'h30, 32'hFFFF_FFFF, 4'hf, n);
        cpu_write(8'h30, 32'h1122_3344, 4'b0101, n);
        cpu_read(8'h30, rd, n);  check("be_merge", rd, 32'hFF22_FF44);

        // Reset while in JRD_WAIT
        jtag(KLoad, 9'h040, 1'b1, '0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        exp_md = '0; mdl_a = 0; exp_err = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("mrst_mondreg", MonDReg, 32'h0);
        check("mrst_ready", 32'(monitor_ready), 32'd0);
        @(posedge clk); #1;
        jtag(KRead, '0, 1'b0, '0);
        wait_ready("mrst_rd", n);
        check("mrst_lat", 32'(n), 32'd2);
        check("mrst_data", MonDReg, 32'hBBBB_0002);

        // Random: JTAG in the low half, CPU in the high half, running concurrently
        fork
            begin
                for (int it = 0; it < 40; it++) begin
                    jtag(KLoad, 9'($urandom_range(0, 'h70)), 1'($urandom), '0);
                    wait_ready("rnd_ld", n);
                    for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                        case ($urandom_range(0, 3))
                            0, 1: jtag(KWrite, '0, 1'b0, $urandom);
                            2: jtag(KRead, '0, 1'b0, '0);
                            default: jtag(KLoad, 9'($urandom_range(256, 511)), 1'b0, '0);
                        endcase
                        wait_ready("rnd_op", n);
                    end
                end
            end
            begin
                logic [31:0] crd;
                int          cw;
                for (int it = 0; it < 150; it++) begin
                    if ($urandom_range(0, 1) == 0)
                        cpu_write(8'($urandom_range(128, 255)), $urandom,
                                  4'($urandom), cw);
                    else
                        cpu_read(8'($urandom_range(128, 255)), crd, cw);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
